fp_result_capture: RTL and testbench
====================================

FP_RESULT_CAPTURE -- requirements
Module: fp_result_capture

Interface
REQ-001 Parameter DEPTH, 8, FIFO entries (power of two, 2..64) SHALL be supported.
REQ-002 Parameter CNT_W, 8, width of each saturating statistic counter.
REQ-003 Clocking SHALL be one clock and reset SHALL be synchronous, active-high.
REQ-004 clock_100kHz  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 qual_lugar  in  3  stage code from the adder; 4 = CHECK completed.
REQ-007 data_in  in  32  adder result: sign[31], exponent[30:25], mantissa[24:0].
REQ-008 status_in  in  4  adder status: 0 exact, 1 overflow, 2 underflow, 3 inexact.
REQ-009 rd_en  in  1  consumer pop request.
REQ-010 rd_valid  out  1  rd_data/rd_status valid this cycle.
REQ-011 rd_data  out  32  popped result word.
REQ-012 rd_status  out  4  popped status code.
REQ-013 empty / full  out  1 each  FIFO flags.
REQ-014 level  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 cnt_exact, cnt_overflow, cnt_underflow, cnt_inexact, cnt_invalid, cnt_dropped  out  CNT_W each  statistics.

Function
REQ-016 Capture FSM SHALL have states IDLE, ARMED, CAPTURE.
REQ-017 IDLE -> ARMED when qual_lugar != 4, else stay.
REQ-018 ARMED -> CAPTURE when qual_lugar == 4, registering data_in and status_in that same cycle.
REQ-019 CAPTURE SHALL last exactly one cycle, issue one write attempt of the registered pair, then -> IDLE.
REQ-020 A qual_lugar held at 4 for many cycles SHALL yield exactly one capture; re-arming requires qual_lugar != 4 first.
REQ-021 Write attempt with full=0, or full=1 with a same-cycle accepted read, SHALL store the entry.
REQ-022 Write attempt with full=1 and no same-cycle read SHALL discard the entry and increment cnt_dropped.
REQ-023 Read: rd_en=1 with empty=0 SHALL pop the oldest entry; rd_valid=1 and rd_data/rd_status valid the following cycle; otherwise rd_valid=0 next cycle.
REQ-024 rd_en with empty=1 SHALL be ignored with no state change; rd_data/rd_status hold last values.
REQ-025 Simultaneous write and read with 0<level<DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-026 Simultaneous write and read with level=0 SHALL NOT bypass: read ignored, write stored, level=1.
REQ-027 Pointers SHALL wrap modulo DEPTH; full=(level==DEPTH), empty=(level==0), both registered consistent with level.
REQ-028 Each capture (stored or dropped) SHALL increment exactly one of cnt_exact/overflow/underflow/inexact by status_in 0..3, or cnt_invalid for 4..15.
REQ-029 All counters SHALL saturate at 2**CNT_W-1, never wrap.
REQ-030 Capture-to-pop latency: entry poppable the cycle after CAPTURE; minimum qual_lugar==4 to rd_valid is 3 cycles.

Reset
REQ-031 On reset: FSM=IDLE, pointers=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_status=0, all counters=0.
REQ-032 Reset SHALL dominate all inputs the same cycle; a pending CAPTURE SHALL be abandoned with no write and no count.
REQ-033 If qual_lugar==4 when reset deasserts, that result SHALL NOT be captured (IDLE rule).

Structure
REQ-034 Package fp_pkg SHALL hold field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=25, MAN_W=25), status enum (ST_EXACT=0, ST_OVERFLOW=1, ST_UNDERFLOW=2, ST_INEXACT=3), and STAGE_CHECK=4.
REQ-035 Storage SHALL be one sub-module fp_result_fifo (synchronous, 36-bit wide, DEPTH deep, registered read); FSM and counters stay in the top.

Verification
REQ-036 Reset, qual_lugar 0->4 (held 5 cycles), data_in=0x4A000000, status_in=0 -> one entry; pop yields rd_data=0x4A000000, rd_status=0; cnt_exact=1.
REQ-037 Nine results (status 1) with no reads, DEPTH=8 -> full=1 after 8, cnt_dropped=1, cnt_overflow=9; 8 pops return first 8 in order.
REQ-038 full=1 with rd_en asserted during CAPTURE -> new entry stored, level stays 8, cnt_dropped unchanged.
REQ-039 status_in=9 captured -> cnt_invalid=1, entry stored with rd_status=9; 300 exact captures (CNT_W=8) -> cnt_exact=255.
REQ-040 Reset asserted during CAPTURE -> level=0, all counters 0; qual_lugar still 4 after release -> no capture until it leaves 4.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder result capture path: result word layout,
// status codes, adder stage code and capture FSM states.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 25;
  localparam int MAN_W    = 25;

  localparam int WORD_W   = 32;
  localparam int STAT_W   = 4;
  localparam int ENTRY_W  = WORD_W + STAT_W;

  localparam logic [2:0] STAGE_CHECK = 3'd4;

  typedef enum logic [3:0] {
    ST_EXACT     = 4'd0,
    ST_OVERFLOW  = 4'd1,
    ST_UNDERFLOW = 4'd2,
    ST_INEXACT   = 4'd3
  } fp_status_e;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/fp_result_fifo.sv
// Synchronous FIFO with registered read port; a write into a full FIFO is
// accepted only when a read frees a slot in the same cycle.
module fp_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_accept, wr_accept;

  // An empty FIFO never bypasses: a same-cycle write only becomes visible next cycle.
  assign rd_accept = rd_en && !empty_q;
  assign wr_accept = wr_en && (!full_q || rd_accept);

  always_comb begin
    wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = rd_accept ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_valid_d = rd_accept;
    rd_data_d  = rd_accept ? mem_q[rd_ptr_q] : rd_data_q;
    case ({wr_accept, rd_accept})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;

endmodule

// File: rtl/fp_result_capture.sv
// Captures one adder result per CHECK stage entry into a FIFO and keeps
// saturating per-status statistics, including results dropped on a full FIFO.
module fp_result_capture
  import fp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clock_100kHz,
  input  logic                    reset,
  input  logic [2:0]              qual_lugar,
  input  logic [31:0]             data_in,
  input  logic [3:0]              status_in,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [31:0]             rd_data,
  output logic [3:0]              rd_status,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        cnt_exact,
  output logic [CNT_W-1:0]        cnt_overflow,
  output logic [CNT_W-1:0]        cnt_underflow,
  output logic [CNT_W-1:0]        cnt_inexact,
  output logic [CNT_W-1:0]        cnt_invalid,
  output logic [CNT_W-1:0]        cnt_dropped
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  cap_state_e        state_q, state_d;
  logic [31:0]       cap_data_q, cap_data_d;
  logic [3:0]        cap_status_q, cap_status_d;
  logic [CNT_W-1:0]  cnt_exact_q, cnt_exact_d;
  logic [CNT_W-1:0]  cnt_overflow_q, cnt_overflow_d;
  logic [CNT_W-1:0]  cnt_underflow_q, cnt_underflow_d;
  logic [CNT_W-1:0]  cnt_inexact_q, cnt_inexact_d;
  logic [CNT_W-1:0]  cnt_invalid_q, cnt_invalid_d;
  logic [CNT_W-1:0]  cnt_dropped_q, cnt_dropped_d;
  logic              capture_fire;
  logic              fifo_full;
  logic [ENTRY_W-1:0] fifo_rd_entry;

  assign capture_fire = (state_q == CAP_CAPTURE);

  always_comb begin
    state_d         = state_q;
    cap_data_d      = cap_data_q;
    cap_status_d    = cap_status_q;
    cnt_exact_d     = cnt_exact_q;
    cnt_overflow_d  = cnt_overflow_q;
    cnt_underflow_d = cnt_underflow_q;
    cnt_inexact_d   = cnt_inexact_q;
    cnt_invalid_d   = cnt_invalid_q;
    cnt_dropped_d   = cnt_dropped_q;

    // Re-arming needs the stage code to leave CHECK, so a held CHECK captures once.
    case (state_q)
      CAP_IDLE: begin
        if (qual_lugar != STAGE_CHECK) state_d = CAP_ARMED;
      end
      CAP_ARMED: begin
        if (qual_lugar == STAGE_CHECK) begin
          state_d      = CAP_CAPTURE;
          cap_data_d   = data_in;
          cap_status_d = status_in;
        end
      end
      CAP_CAPTURE: state_d = CAP_IDLE;
      default:     state_d = CAP_IDLE;
    endcase

    if (capture_fire) begin
      case (cap_status_q)
        ST_EXACT:     cnt_exact_d     = sat_inc(cnt_exact_q);
        ST_OVERFLOW:  cnt_overflow_d  = sat_inc(cnt_overflow_q);
        ST_UNDERFLOW: cnt_underflow_d = sat_inc(cnt_underflow_q);
        ST_INEXACT:   cnt_inexact_d   = sat_inc(cnt_inexact_q);
        default:      cnt_invalid_d   = sat_inc(cnt_invalid_q);
      endcase
      // A full FIFO is never empty, so any rd_en here is an accepted read.
      if (fifo_full && !rd_en) cnt_dropped_d = sat_inc(cnt_dropped_q);
    end
  end

  always_ff @(posedge clock_100kHz) begin
    cap_data_q   <= cap_data_d;
    cap_status_q <= cap_status_d;
    if (reset) begin
      state_q         <= CAP_IDLE;
      cnt_exact_q     <= '0;
      cnt_overflow_q  <= '0;
      cnt_underflow_q <= '0;
      cnt_inexact_q   <= '0;
      cnt_invalid_q   <= '0;
      cnt_dropped_q   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_exact_q     <= cnt_exact_d;
      cnt_overflow_q  <= cnt_overflow_d;
      cnt_underflow_q <= cnt_underflow_d;
      cnt_inexact_q   <= cnt_inexact_d;
      cnt_invalid_q   <= cnt_invalid_d;
      cnt_dropped_q   <= cnt_dropped_d;
    end
  end

  fp_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clock_100kHz),
    .reset    (reset),
    .wr_en    (capture_fire),
    .wr_data  ({cap_status_q, cap_data_q}),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (fifo_rd_entry),
    .empty    (empty),
    .full     (fifo_full),
    .level    (level)
  );

  assign full          = fifo_full;
  assign rd_status     = fifo_rd_entry[ENTRY_W-1:WORD_W];
  assign rd_data       = fifo_rd_entry[WORD_W-1:0];
  assign cnt_exact     = cnt_exact_q;
  assign cnt_overflow  = cnt_overflow_q;
  assign cnt_underflow = cnt_underflow_q;
  assign cnt_inexact   = cnt_inexact_q;
  assign cnt_invalid   = cnt_invalid_q;
  assign cnt_dropped   = cnt_dropped_q;

endmodule

// File: tb/tb_fp_result_capture.sv
// Scenario bench for fp_result_capture: expected FIFO entries are queued as
// captures are driven and compared in order whenever rd_valid appears.
module tb_fp_result_capture;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  qual;
  logic [31:0] data_in;
  logic [3:0]  status_in;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_status;
  logic        empty, full;
  logic [3:0]  level;
  logic [CNT_W-1:0] cnt_exact, cnt_overflow, cnt_underflow, cnt_inexact, cnt_invalid, cnt_dropped;
  logic [CNT_W-1:0] dut_cnt [6];

  int vectors = 0;
  int miscompares = 0;
  int exp_level = 0;
  int exp_pops = 0;
  int exp_cnt [6];
  logic [35:0] sbq [$];

  always #5 clk = ~clk;

  fp_result_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock_100kHz  (clk),
    .reset         (reset),
    .qual_lugar    (qual),
    .data_in       (data_in),
    .status_in     (status_in),
    .rd_en         (rd_en),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_status     (rd_status),
    .empty         (empty),
    .full          (full),
    .level         (level),
    .cnt_exact     (cnt_exact),
    .cnt_overflow  (cnt_overflow),
    .cnt_underflow (cnt_underflow),
    .cnt_inexact   (cnt_inexact),
    .cnt_invalid   (cnt_invalid),
    .cnt_dropped   (cnt_dropped)
  );

  always_comb begin
    dut_cnt[0] = cnt_exact;
    dut_cnt[1] = cnt_overflow;
    dut_cnt[2] = cnt_underflow;
    dut_cnt[3] = cnt_inexact;
    dut_cnt[4] = cnt_invalid;
    dut_cnt[5] = cnt_dropped;
  end

  // Pop monitor: every rd_valid must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      vectors++;
      if (exp_pops == 0 || sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rd_valid: got data=%h status=%0d, no pop outstanding", rd_data, rd_status);
      end else begin
        logic [35:0] e;
        e = sbq.pop_front();
        exp_pops--;
        if ({rd_status, rd_data} !== e) begin
          miscompares++;
          $display("FAIL pop_entry: got status=%0d data=%h, want status=%0d data=%h",
                   rd_status, rd_data, e[35:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; qual = 3'd0; rd_en = 1'b0;
    tick(); tick();
    sbq.delete();
    exp_level = 0; exp_pops = 0;
    for (int k = 0; k < 6; k++) exp_cnt[k] = 0;
    reset = 1'b0;
  endtask

  // Arms, presents CHECK for one cycle, and optionally reads during the CAPTURE cycle.
  task automatic capture(input logic [31:0] d, input logic [3:0] s, input bit rd);
    bit rd_acc, stored;
    qual = 3'd1; data_in = d; status_in = s;
    tick(); tick();
    qual = 3'd4;
    tick();
    qual = 3'd1; rd_en = rd;
    rd_acc = rd && (exp_level > 0);
    stored = (exp_level < DEPTH) || rd_acc;
    if (rd_acc) begin exp_pops++; exp_level--; end
    if (stored) begin sbq.push_back({s, d}); exp_level++; end
    else exp_cnt[5] = sat(exp_cnt[5]);
    if (s < 4) exp_cnt[s] = sat(exp_cnt[s]);
    else exp_cnt[4] = sat(exp_cnt[4]);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    if (exp_level > 0) begin exp_pops++; exp_level--; end
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 6;
    if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
    if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
    if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    if (rd_status !== 4'h0) begin miscompares++; $display("FAIL reset_rd_status: got %0d want 0", rd_status); end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (dut_cnt[k] !== 8'd0) begin miscompares++; $display("FAIL reset_cnt%0d: got %0d want 0", k, dut_cnt[k]); end
    end
  endtask

  task automatic test_basic();
    do_reset();
    data_in = 32'h4A00_0000; status_in = 4'd0;
    qual = 3'd0; tick();
    qual = 3'd4; repeat (5) tick();
    sbq.push_back({4'd0, 32'h4A00_0000}); exp_level = 1; exp_cnt[0] = 1;
    vectors += 2;
    if (level !== 4'd1) begin miscompares++; $display("FAIL basic_level: got %0d want 1", level); end
    if (cnt_exact !== 8'd1) begin miscompares++; $display("FAIL basic_cnt_exact: got %0d want 1", cnt_exact); end
    qual = 3'd0;
    pop();
    vectors += 3;
    if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL basic_rd_valid: got %b want 1", rd_valid); end
    if (rd_data !== 32'h4A00_0000) begin miscompares++; $display("FAIL basic_rd_data: got %h want 4a000000", rd_data); end
    if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty: got %b want 1", empty); end
    tick();
    vectors++;
    if (exp_pops != 0) begin miscompares++; $display("FAIL basic_pops_seen: got %0d outstanding want 0", exp_pops); end
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    vectors += 2;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL empty_rd_valid: got %b want 0", rd_valid); end
    if (level !== 4'd0) begin miscompares++; $display("FAIL empty_level: got %0d want 0", level); end
    capture(32'hC1A0_0001, 4'd2, 1'b1);
    vectors += 2;
    if (level !== 4'd1) begin miscompares++; $display("FAIL nobypass_level: got %0d want 1", level); end
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL nobypass_rd_valid: got %b want 0", rd_valid); end
    capture(32'h0BAD_F00D, 4'd3, 1'b1);
    vectors++;
    if (level !== 4'd1) begin miscompares++; $display("FAIL rw_level: got %0d want 1", level); end
    pop();
    tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    vectors += 4;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL empty_rd2_valid: got %b want 0", rd_valid); end
    if (rd_data !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL hold_rd_data: got %h want 0badf00d", rd_data); end
    if (dut_cnt[2] !== 8'd1 || dut_cnt[3] !== 8'd1) begin
      miscompares++; $display("FAIL rw_counts: got und=%0d inx=%0d want 1 1", dut_cnt[2], dut_cnt[3]);
    end
    if (exp_pops != 0) begin miscompares++; $display("FAIL rw_pops_seen: got %0d outstanding want 0", exp_pops); end
  endtask

  task automatic test_overflow_drop();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      capture(32'h1000_0000 + i, 4'd1, 1'b0);
      if (i == 7) begin
        vectors += 2;
        if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", full); end
        if (level !== 4'd8) begin miscompares++; $display("FAIL ovf_level: got %0d want 8", level); end
      end
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (dut_cnt[k] !== exp_cnt[k][7:0]) begin miscompares++; $display("FAIL ovf_cnt%0d: got %0d want %0d", k, dut_cnt[k], exp_cnt[k]); end
    end
    repeat (8) pop();
    tick();
    vectors += 2;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_empty: got %b want 1", empty); end
    if (exp_pops != 0) begin miscompares++; $display("FAIL ovf_pops_seen: got %0d outstanding want 0", exp_pops); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 8; i++) capture(32'h2000_0000 + i, 4'd3, 1'b0);
    capture(32'h2000_00FF, 4'd0, 1'b1);
    vectors += 3;
    if (level !== 4'd8) begin miscompares++; $display("FAIL fullrw_level: got %0d want 8", level); end
    if (full !== 1'b1) begin miscompares++; $display("FAIL fullrw_full: got %b want 1", full); end
    if (cnt_dropped !== 8'd0) begin miscompares++; $display("FAIL fullrw_dropped: got %0d want 0", cnt_dropped); end
    repeat (8) pop();
    tick();
    vectors += 2;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL fullrw_empty: got %b want 1", empty); end
    if (exp_pops != 0) begin miscompares++; $display("FAIL fullrw_pops_seen: got %0d outstanding want 0", exp_pops); end
  endtask

  task automatic test_invalid_sat();
    do_reset();
    capture(32'h7F80_0000, 4'd9, 1'b0);
    vectors++;
    if (cnt_invalid !== 8'd1) begin miscompares++; $display("FAIL invalid_cnt: got %0d want 1", cnt_invalid); end
    pop();
    for (int i = 0; i < 300; i++) capture(32'h3000_0000 + i, 4'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (dut_cnt[k] !== exp_cnt[k][7:0]) begin miscompares++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, dut_cnt[k], exp_cnt[k]); end
    end
    repeat (8) pop();
    tick();
    vectors++;
    if (exp_pops != 0) begin miscompares++; $display("FAIL sat_pops_seen: got %0d outstanding want 0", exp_pops); end
  endtask

  task automatic test_reset_capture();
    do_reset();
    capture(32'h4000_0001, 4'd0, 1'b0);
    qual = 3'd1; tick(); tick();
    qual = 3'd4; tick();
    reset = 1'b1; tick();
    sbq.delete(); exp_level = 0; exp_pops = 0;
    for (int k = 0; k < 6; k++) exp_cnt[k] = 0;
    reset = 1'b0;
    vectors += 2;
    if (level !== 4'd0) begin miscompares++; $display("FAIL rstcap_level: got %0d want 0", level); end
    if (cnt_exact !== 8'd0) begin miscompares++; $display("FAIL rstcap_cnt_exact: got %0d want 0", cnt_exact); end
    repeat (5) tick();
    vectors += 2;
    if (level !== 4'd0) begin miscompares++; $display("FAIL held4_level: got %0d want 0", level); end
    if (cnt_exact !== 8'd0) begin miscompares++; $display("FAIL held4_cnt_exact: got %0d want 0", cnt_exact); end
    capture(32'h4000_0002, 4'd0, 1'b0);
    vectors += 2;
    if (level !== 4'd1) begin miscompares++; $display("FAIL rearm_level: got %0d want 1", level); end
    if (cnt_exact !== 8'd1) begin miscompares++; $display("FAIL rearm_cnt_exact: got %0d want 1", cnt_exact); end
    pop();
    tick();
    vectors++;
    if (exp_pops != 0) begin miscompares++; $display("FAIL rearm_pops_seen: got %0d outstanding want 0", exp_pops); end
  endtask

  initial begin
    reset = 1'b1; qual = 3'd0; data_in = '0; status_in = '0; rd_en = 1'b0;
    test_reset();
    test_basic();
    test_empty_read();
    test_overflow_drop();
    test_full_rw();
    test_invalid_sat();
    test_reset_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
